muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter W, default 16: operand/result width, W >= 4.
REQ-002 Parameter NREG, default 4: number of source registers; select width SW = clog2(NREG).
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  operation request, sampled only when busy=0.
REQ-006 op  in  2  00 SHL, 01 MUL, 10 DIV, 11 SHR.
REQ-007 sgn  in  1  1 = signed MUL/DIV and arithmetic SHR; ignored for SHL.
REQ-008 sel1, sel2  in  SW each  source register index for operand A and operand B.
REQ-009 regs  in  NREG*W  packed register file, register k at bits [k*W +: W].
REQ-010 busy  out  1  operation in progress.
REQ-011 done  out  1  one-cycle pulse, result valid.
REQ-012 result  out  W  low product, quotient or shifted value; held until next done.
REQ-013 rem  out  W  remainder after DIV; 0 after other ops.
REQ-014 dbz  out  1  divide-by-zero flag, valid with done.
REQ-015 ovf  out  1  MUL high half not sign/zero extension, or signed DIV MIN/-1; valid with done.

Function
REQ-016 Operands A = regs[sel1], B = regs[sel2] SHALL be captured into internal registers on accepted start; later regs changes SHALL not affect the operation.
REQ-017 FSM states IDLE, SHIFT, MUL, DIV, FIX, DONE; IDLE -> op state on start; op state -> FIX (MUL/DIV) or DONE (SHIFT); FIX -> DONE; DONE -> IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-019 SHL/SHR SHALL use amount B[clog2(W)-1:0] covering 0..W-1; latency start-to-done 2 cycles.
REQ-020 MUL SHALL be radix-2 shift-add on magnitudes, one bit per cycle, W cycles, then FIX applies sign; start-to-done W+3 cycles.
REQ-021 DIV SHALL be restoring division on magnitudes, W cycles, then FIX; quotient sign = sign(A) xor sign(B), remainder sign = sign(A).
REQ-022 DIV with B = 0 SHALL skip iteration: DONE next cycle, result all ones, rem = A, dbz = 1.
REQ-023 Signed DIV of most-negative by -1 SHALL give result = most-negative, rem = 0, ovf = 1.
REQ-024 MUL ovf SHALL be set when the 2W-bit product does not fit in W bits (unsigned or signed per sgn).
REQ-025 done SHALL assert for exactly one cycle in DONE; result/rem/dbz/ovf SHALL update on the same edge and hold until the next done.
REQ-026 start asserted in the DONE cycle SHALL be ignored; accepted again from IDLE.
REQ-027 Iteration counter SHALL be clog2(W)+1 bits and never wrap within an operation.

Reset
REQ-028 rst low SHALL immediately force IDLE, busy=0, done=0, result=0, rem=0, dbz=0, ovf=0, and clear operand and counter registers.
REQ-029 Reset mid-operation SHALL abort without a done pulse; first start after release SHALL behave as from power-up.

Structure
REQ-030 Op encodings and FSM state enum SHALL live in shared package muldiv_pkg.
REQ-031 Barrel shifter SHALL be sub-module mds_shift (W-parameterised, combinational, SHL/SHR logical/arithmetic).
REQ-032 Multiplier and divider SHALL share one 2W-bit accumulator and one W-bit adder/subtractor.

Verification
REQ-033 W=16: A=0x0003, B=0x0004, op MUL, sgn 0 -> done at cycle 19, result 0x000C, ovf 0.
REQ-034 W=16: A=0xFFF9 (-7), B=0x0002, op DIV, sgn 1 -> result 0xFFFD (-3), rem 0xFFFF (-1), dbz 0.
REQ-035 A=0x1234, B=0 op DIV -> done 2 cycles after start, result 0xFFFF, rem 0x1234, dbz 1.
REQ-036 A=0x8000, B=0x000F op SHR sgn 1 -> result 0xFFFF; sgn 0 -> 0x0001; op SHL B=0 -> 0x8000.
REQ-037 A=0x8000, B=0xFFFF signed DIV -> result 0x8000, ovf 1; A=0x0100, B=0x0100 MUL -> result 0x0000, ovf 1.
REQ-038 start during MUL busy ignored; rst low at iteration 5 -> busy 0 immediately, no done, next MUL correct.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide/shift unit:
// operation encodings and controller state encoding.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_SHL = 2'b00,
    OP_MUL = 2'b01,
    OP_DIV = 2'b10,
    OP_SHR = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_MUL   = 3'd2,
    ST_DIV   = 3'd3,
    ST_FIX   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mds_shift.sv
// Combinational barrel shifter: logical left, logical right or arithmetic right.
module mds_shift #(
  parameter int W = 16
) (
  input  logic [W-1:0]         a,
  input  logic [$clog2(W)-1:0] amt,
  input  logic                 left,
  input  logic                 arith,
  output logic [W-1:0]         y
);

  // Kept in its own signed net so the sign fill survives the output mux.
  logic signed [W-1:0] sra;
  assign sra = $signed(a) >>> amt;

  always_comb begin
    if (left)       y = a << amt;
    else if (arith) y = sra;
    else            y = a >> amt;
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential shift / multiply / divide unit reading two operands from a packed
// register file; MUL and DIV iterate on magnitudes and fix the sign at the end.
import muldiv_pkg::*;

module muldiv_seq #(
  parameter int W    = 16,
  parameter int NREG = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic                     sgn,
  input  logic [$clog2(NREG)-1:0]  sel1,
  input  logic [$clog2(NREG)-1:0]  sel2,
  input  logic [NREG*W-1:0]        regs,
  output logic                     busy,
  output logic                     done,
  output logic [W-1:0]             result,
  output logic [W-1:0]             rem,
  output logic                     dbz,
  output logic                     ovf
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W);

  logic [W-1:0] reg_arr [NREG];
  for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
    assign reg_arr[gi] = regs[gi*W +: W];
  end

  state_t         state_reg, state_next;
  op_t            op_reg;
  logic           sgn_reg;
  logic [W-1:0]   opa_reg, opb_reg;
  logic [2*W-1:0] acc_reg, acc_next;
  logic [CW-1:0]  cnt_reg;
  logic           done_reg, dbz_reg, ovf_reg;
  logic [W-1:0]   result_reg, rem_reg;

  logic [W-1:0] mag_a, mag_b;
  logic         b_zero, is_div;
  assign mag_a  = (sgn_reg && opa_reg[W-1]) ? -opa_reg : opa_reg;
  assign mag_b  = (sgn_reg && opb_reg[W-1]) ? -opb_reg : opb_reg;
  assign b_zero = (opb_reg == '0);
  assign is_div = (op_reg == OP_DIV);

  // Single W-bit adder shared by both loops: add multiplicand or subtract divisor.
  logic [W-1:0] add_a, add_b;
  logic [W:0]   add_sum;
  logic         div_ok;
  assign add_a   = is_div ? acc_reg[2*W-2:W-1] : acc_reg[2*W-1:W];
  assign add_b   = is_div ? ~mag_b : mag_b;
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, is_div};
  // The bit shifted out of the remainder guarantees the subtraction fits.
  assign div_ok  = add_sum[W] | acc_reg[2*W-1];

  always_comb begin
    if (is_div)
      acc_next = div_ok ? {add_sum[W-1:0], acc_reg[W-2:0], 1'b1} : {acc_reg[2*W-2:0], 1'b0};
    else
      acc_next = acc_reg[0] ? {add_sum, acc_reg[W-1:1]} : {1'b0, acc_reg[2*W-1:1]};
  end

  logic [W-1:0] shift_y;
  mds_shift #(.W(W)) u_shift (
    .a     (opa_reg),
    .amt   (opb_reg[$clog2(W)-1:0]),
    .left  (op_reg == OP_SHL),
    .arith (sgn_reg && (op_reg == OP_SHR)),
    .y     (shift_y)
  );

  logic [2*W-1:0] prod_s;
  logic [W:0]     prod_hi;
  logic           mul_ovf, div_ovf;
  logic [W-1:0]   quo_s, rem_s;
  assign prod_s  = (sgn_reg && (opa_reg[W-1] ^ opb_reg[W-1])) ? -acc_reg : acc_reg;
  assign prod_hi = prod_s[2*W-1:W-1];
  assign mul_ovf = sgn_reg ? !((&prod_hi) || !(|prod_hi)) : (|acc_reg[2*W-1:W]);
  assign quo_s   = (sgn_reg && (opa_reg[W-1] ^ opb_reg[W-1])) ? -acc_reg[W-1:0] : acc_reg[W-1:0];
  assign rem_s   = (sgn_reg && opa_reg[W-1]) ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];
  assign div_ovf = sgn_reg && (opa_reg == {1'b1, {(W-1){1'b0}}}) && (&opb_reg);

  logic [W-1:0] fin_res, fin_rem;
  logic         fin_dbz, fin_ovf;
  always_comb begin
    fin_res = '0;
    fin_rem = '0;
    fin_dbz = 1'b0;
    fin_ovf = 1'b0;
    case (state_reg)
      ST_SHIFT: fin_res = shift_y;
      ST_DIV: begin
        fin_res = '1;
        fin_rem = opa_reg;
        fin_dbz = 1'b1;
      end
      ST_FIX: begin
        if (is_div) begin
          fin_res = quo_s;
          fin_rem = rem_s;
          fin_ovf = div_ovf;
        end else begin
          fin_res = prod_s[W-1:0];
          fin_ovf = mul_ovf;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:
        if (start) begin
          case (op_t'(op))
            OP_MUL:  state_next = ST_MUL;
            OP_DIV:  state_next = ST_DIV;
            default: state_next = ST_SHIFT;
          endcase
        end
      ST_SHIFT: state_next = ST_DONE;
      ST_MUL:   if (cnt_reg == CNT_LAST) state_next = ST_FIX;
      ST_DIV: begin
        if (cnt_reg == '0 && b_zero)     state_next = ST_DONE;
        else if (cnt_reg == CNT_LAST)    state_next = ST_FIX;
      end
      ST_FIX:   state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      op_reg     <= OP_SHL;
      sgn_reg    <= 1'b0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      rem_reg    <= '0;
      dbz_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE:
          if (start) begin
            opa_reg <= reg_arr[sel1];
            opb_reg <= reg_arr[sel2];
            op_reg  <= op_t'(op);
            sgn_reg <= sgn;
            cnt_reg <= '0;
          end
        ST_MUL, ST_DIV: begin
          // Count 0 loads the dividend/multiplier magnitude; 1..W iterate.
          if (cnt_reg == '0) begin
            acc_reg <= {{W{1'b0}}, mag_a};
            cnt_reg <= cnt_reg + 1'b1;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
      if (state_next == ST_DONE) begin
        done_reg   <= 1'b1;
        result_reg <= fin_res;
        rem_reg    <= fin_rem;
        dbz_reg    <= fin_dbz;
        ovf_reg    <= fin_ovf;
      end
    end
  end

  assign busy   = (state_reg != ST_IDLE);
  assign done   = done_reg;
  assign result = result_reg;
  assign rem    = rem_reg;
  assign dbz    = dbz_reg;
  assign ovf    = ovf_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: table of hand-computed vectors plus sequences
// for busy-time start, start in the DONE cycle and mid-operation reset.
module tb_muldiv_seq;

  localparam int W    = 16;
  localparam int NREG = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic            sgn;
  logic [1:0]      sel1, sel2;
  logic [NREG*W-1:0] regs;
  logic            busy, done, dbz, ovf;
  logic [W-1:0]    result, rem;

  always #5 clk = ~clk;

  muldiv_seq #(.W(W), .NREG(NREG)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .sgn    (sgn),
    .sel1   (sel1),
    .sel2   (sel2),
    .regs   (regs),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rem    (rem),
    .dbz    (dbz),
    .ovf    (ovf)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic        s;
    logic [15:0] res;
    logic [15:0] rm;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  localparam logic [1:0] SHL = 2'b00, MUL = 2'b01, DIV = 2'b10, SHR = 2'b11;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vt [21];

  // Called at a negedge; leaves the bench just after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                       input logic s, input int k);
    regs = {$urandom, $urandom};
    regs[(k % 4)*16 +: 16]       = a;
    regs[((k + 1) % 4)*16 +: 16] = b;
    sel1  = 2'(k % 4);
    sel2  = 2'((k + 1) % 4);
    op    = o;
    sgn   = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    regs  = {$urandom, $urandom};
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_op(input string tag, input logic [15:0] er, input logic [15:0] erm,
                          input logic edz, input logic eov, input int elat);
    int lat;
    logic [15:0] r, m;
    logic z, v, d2;
    wait_done(lat);
    r = result; m = rem; z = dbz; v = ovf;
    @(negedge clk);
    d2 = done;
    n_vec++;
    if (lat != elat || r !== er || m !== erm || z !== edz || v !== eov || d2 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got res=%h rem=%h dbz=%b ovf=%b lat=%0d done_after=%b; want res=%h rem=%h dbz=%b ovf=%b lat=%0d done_after=0",
               tag, r, m, z, v, lat, d2, er, erm, edz, eov, elat);
    end else begin
      $display("ok   %s: res=%h rem=%h dbz=%b ovf=%b lat=%0d", tag, r, m, z, v, lat);
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  initial begin
    int lat;
    //        a        b        op   s  res      rem      dz ov lat
    vt[0]  = '{16'h0003, 16'h0004, MUL, 0, 16'h000C, 16'h0000, 0, 0, 19};
    vt[1]  = '{16'hFFF9, 16'h0002, DIV, 1, 16'hFFFD, 16'hFFFF, 0, 0, 19};
    vt[2]  = '{16'h1234, 16'h0000, DIV, 0, 16'hFFFF, 16'h1234, 1, 0, 2};
    vt[3]  = '{16'h8000, 16'h000F, SHR, 1, 16'hFFFF, 16'h0000, 0, 0, 2};
    vt[4]  = '{16'h8000, 16'h000F, SHR, 0, 16'h0001, 16'h0000, 0, 0, 2};
    vt[5]  = '{16'h8000, 16'h0000, SHL, 0, 16'h8000, 16'h0000, 0, 0, 2};
    vt[6]  = '{16'h8000, 16'hFFFF, DIV, 1, 16'h8000, 16'h0000, 0, 1, 19};
    vt[7]  = '{16'h0100, 16'h0100, MUL, 0, 16'h0000, 16'h0000, 0, 1, 19};
    vt[8]  = '{16'hFFFD, 16'h0005, MUL, 1, 16'hFFF1, 16'h0000, 0, 0, 19};
    vt[9]  = '{16'h8000, 16'hFFFF, MUL, 1, 16'h8000, 16'h0000, 0, 1, 19};
    vt[10] = '{16'hFFFF, 16'hFFFF, MUL, 0, 16'h0001, 16'h0000, 0, 1, 19};
    vt[11] = '{16'h00FF, 16'h0010, DIV, 0, 16'h000F, 16'h000F, 0, 0, 19};
    vt[12] = '{16'h0007, 16'hFFFE, DIV, 1, 16'hFFFD, 16'h0001, 0, 0, 19};
    vt[13] = '{16'hFFFF, 16'h0001, DIV, 0, 16'hFFFF, 16'h0000, 0, 0, 19};
    vt[14] = '{16'h0001, 16'h0013, SHL, 0, 16'h0008, 16'h0000, 0, 0, 2};
    vt[15] = '{16'h7000, 16'h0004, SHR, 1, 16'h0700, 16'h0000, 0, 0, 2};
    vt[16] = '{16'h8000, 16'hFFFF, DIV, 0, 16'h0000, 16'h8000, 0, 0, 19};
    vt[17] = '{16'h0100, 16'hFFFF, MUL, 1, 16'hFF00, 16'h0000, 0, 0, 19};
    vt[18] = '{16'h00FF, 16'h0008, SHL, 1, 16'hFF00, 16'h0000, 0, 0, 2};
    vt[19] = '{16'h0000, 16'h0005, DIV, 1, 16'h0000, 16'h0000, 0, 0, 19};
    vt[20] = '{16'hFFF9, 16'h0000, DIV, 1, 16'hFFFF, 16'hFFF9, 1, 0, 2};

    rst = 1'b0; start = 1'b0; op = 2'b00; sgn = 1'b0;
    sel1 = 2'd0; sel2 = 2'd0; regs = '0;
    #12;
    cmp("reset_outputs", {26'd0, busy, done, dbz, ovf, 2'b00}, 32'd0);
    cmp("reset_result_rem", {result, rem}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      issue(vt[i].a, vt[i].b, vt[i].op, vt[i].s, i);
      check_op($sformatf("vec%0d", i), vt[i].res, vt[i].rm, vt[i].dz, vt[i].ov, vt[i].lat);
    end

    // start while MUL is busy must be ignored
    issue(16'h0003, 16'h0004, MUL, 1'b0, 0);
    repeat (4) @(negedge clk);
    regs = {$urandom, $urandom};
    op = SHL; sel1 = 2'd2; sel2 = 2'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_op("start_while_busy", 16'h000C, 16'h0000, 1'b0, 1'b0, 15);

    // start held in the DONE cycle must not launch a new operation
    issue(16'h0001, 16'h0001, SHL, 1'b0, 1);
    wait_done(lat);
    cmp("shl_done_latency", lat, 32'd2);
    cmp("shl_result", {16'h0, result}, 32'h0000_0002);
    op = SHL; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    cmp("start_in_done_ignored_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset in the middle of a MUL
    issue(16'h0003, 16'h0004, MUL, 1'b0, 2);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("midop_reset_busy", {31'd0, busy}, 32'd0);
    cmp("midop_reset_result", {16'h0, result}, 32'd0);
    lat = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) lat++;
    end
    cmp("no_done_during_reset", lat, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    issue(16'h0005, 16'h0007, MUL, 1'b0, 3);
    check_op("mul_after_reset", 16'h0023, 16'h0000, 1'b0, 1'b0, 19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
